down_counter_4_bit: RTL

Loadable, cascadable binary down counter with terminal-count borrow, optional auto-reload and a sticky expiry flag. It is the count-down companion to the team's 4-bit up counter. It serves as a programmable period timer or delay stage. It also chains with other instances to build wider down counters.

---
 rtl/down_counter_4_bit.sv | 46 ++++
 1 files changed

// File: rtl/down_counter_4_bit.sv
// Loadable, cascadable down counter with terminal-count borrow, optional
// auto-reload from the last loaded value, and a sticky underflow flag.
module down_counter_4_bit #(
  parameter int WIDTH     = 4,
  parameter int RELOAD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             done
);

  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] wrap_val;

  // Underflow target: stored load value, or all-ones for a plain wide chain.
  assign wrap_val = (RELOAD_EN != 0) ? rld : {WIDTH{1'b1}};

  assign zero   = (q == '0);
  assign borrow = en & ~load & zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      rld  <= '0;
      done <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      rld  <= load_val;
      done <= 1'b0;
    end else if (en) begin
      if (zero) begin
        q    <= wrap_val;
        done <= 1'b1;
      end else begin
        q    <= q - WIDTH'(1);
      end
    end
  end

endmodule
